// File: rtl/imem_loader.sv
// Program loader: assembles a big-endian byte stream into 32-bit words and writes them to imem
// from word 0 upward, holding the core in reset until a clean load. Optional trailer check: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] n_words;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xsum;
`endif

  logic        xfer;
  logic        last_word;
  logic [15:0] len_c;

  assign xfer      = rx_valid & rx_ready;
  assign last_word = (words_loaded + 16'd1) == n_words;
  assign len_c     = {len_hi, rx_data};

  // Single-process FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= 32'd0;
      imem_wdata   <= 32'd0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= 16'd0;
      len_hi       <= 8'd0;
      n_words      <= 16'd0;
      byte_cnt     <= 2'd0;
      shift        <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xsum         <= 8'd0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN_HI;
            rx_ready     <= 1'b1;
            busy         <= 1'b1;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 16'd0;
            byte_cnt     <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum         <= 8'd0;
`endif
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= rx_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            n_words <= len_c;
            if (32'(len_c) > DEPTH) begin
              state    <= S_ERR;
              busy     <= 1'b0;
              err      <= 1'b1;
              rx_ready <= 1'b0;
            end else if (len_c == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state     <= S_CHK;
`else
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
              rx_ready  <= 1'b0;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // rx_ready low here means the final strobe is on the bus; finish after it.
          if (!rx_ready) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else if (xfer) begin
            shift    <= {shift[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum     <= xsum ^ rx_data;
`endif
            if (byte_cnt == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= 32'({words_loaded[ADDR_W-1:0], 2'b00});
              imem_wdata   <= {shift, rx_data};
              words_loaded <= words_loaded + 16'd1;
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state    <= S_CHK;
`else
                rx_ready <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            busy     <= 1'b0;
            rx_ready <= 1'b0;
            if (rx_data == xsum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames built from a word list, imem writes collected
// and compared against the list and the expected completion status.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit bp = 1'b0;
  logic [31:0] exp_words[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: each strobe is high for exactly one cycle, so one negedge sees it.
  always @(negedge clk) begin
    if (imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    if (bp) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    k = 0;
    while (1) begin
      @(negedge clk);
      if (rx_ready) break;
      k++;
      if (k > 50) begin
        check("rx_ready_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Sends a whole frame for length n using exp_words as payload, then checks the outcome.
  task automatic run_load(input logic [15:0] n, input bit bad_sum);
    bit ok_len, exp_fail;
    logic [7:0] xs;
    logic [31:0] w;
    int k;
    got_addr.delete();
    got_data.delete();
    ok_len = (n <= 16'd256);
    xs = 8'h00;
    pulse_start();
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    if (ok_len) begin
      for (int i = 0; i < int'(n); i++) begin
        w = exp_words[i];
        for (int j = 3; j >= 0; j--) begin
          send_byte(w[8*j +: 8]);
          xs = xs ^ w[8*j +: 8];
        end
      end
    end
    exp_fail = !ok_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (ok_len) begin
      send_byte(xs ^ {7'd0, bad_sum});
      exp_fail = bad_sum;
    end
`else
    if (bad_sum) exp_fail = 1'b1;
`endif
    k = 0;
    while (!(done || err)) begin
      @(negedge clk);
      k++;
      if (k > 300) begin
        check("finish_timeout", 32'd0, 32'd1);
        break;
      end
    end
    check("done", 32'(done), 32'(!exp_fail));
    check("err", 32'(err), 32'(exp_fail));
    check("cpu_reset", 32'(cpu_reset), 32'(exp_fail));
    check("busy_end", 32'(busy), 32'd0);
    check("rx_ready_end", 32'(rx_ready), 32'd0);
    check("words_loaded", 32'(words_loaded), ok_len ? 32'(n) : 32'd0);
    check("write_count", 32'(got_addr.size()), ok_len ? 32'(n) : 32'd0);
    for (int i = 0; i < got_addr.size() && i < exp_words.size(); i++) begin
      check("wr_addr", got_addr[i], 32'(i * 4));
      check("wr_data", got_data[i], exp_words[i]);
    end
  endtask

  task automatic rand_words(input int n);
    exp_words.delete();
    for (int i = 0; i < n; i++) exp_words.push_back($urandom);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    #12;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    reset_n = 1'b1;

    // Fixed two-word program, then the same with random stalls
    exp_words.delete();
    exp_words.push_back(32'h20080006);
    exp_words.push_back(32'h20090004);
    run_load(16'd2, 1'b0);
    bp = 1'b1;
    run_load(16'd2, 1'b0);

    // Oversize length goes to ERR; start then re-arms
    bp = 1'b0;
    run_load(16'h0101, 1'b0);
    pulse_start();
    @(negedge clk);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_rx_ready", 32'(rx_ready), 32'd1);
    check("restart_err", 32'(err), 32'd0);
    check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    rand_words(3);
    run_load(16'd3, 1'b0);

    // Empty program
    exp_words.delete();
    run_load(16'd0, 1'b0);

    // Random programs with random stalls
    bp = 1'b1;
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 9);
      rand_words(n);
      run_load(16'(n), 1'b0);
    end

    // Full memory: last write lands at byte address 1020
    bp = 1'b0;
    rand_words(256);
    run_load(16'd256, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_words.delete();
    exp_words.push_back(32'h12345678);
    run_load(16'd1, 1'b0);
    run_load(16'd1, 1'b1);
`endif

    // Reset mid-DATA returns all outputs to reset values immediately
    rand_words(4);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h04);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    check("mid_rst_we", 32'(imem_we), 32'd0);
    check("mid_rst_addr", imem_addr, 32'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mid_rst_flags", {29'd0, busy, done, err}, 32'd0);
    check("mid_rst_words", 32'(words_loaded), 32'd0);
    #10 reset_n = 1'b1;

    rand_words(2);
    run_load(16'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
